// File: rtl/icache_responder_if.sv
// Fetch-side request/response and memory-side refill handshake bundle for icache_responder.
// The cache connects through the slave modport; the fetch stage / memory arbiter through master.
interface icache_responder_if;
    logic        to_icache;
    logic [31:0] pc_to_icache;
    logic        flush;
    logic        have_result;
    logic [31:0] inst_from_icache;
    logic        mem_valid;
    logic [31:0] mem_addr;
    logic        mem_ready;
    logic [31:0] mem_data;

    modport master (
        output to_icache, pc_to_icache, flush, mem_ready, mem_data,
        input  have_result, inst_from_icache, mem_valid, mem_addr
    );

    modport slave (
        input  to_icache, pc_to_icache, flush, mem_ready, mem_data,
        output have_result, inst_from_icache, mem_valid, mem_addr
    );
endinterface

// File: rtl/icache_responder.sv
// Direct-mapped instruction cache: 1-cycle hits, in-order whole-line refill on miss.
// Optional ICACHE_STATS_EN macro adds hit_count/miss_count lookup counters.
module icache_responder #(
    parameter int INDEX_WIDTH  = 6,
    parameter int OFFSET_WIDTH = 2
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              rdy_in,
    icache_responder_if.slave bus
`ifdef ICACHE_STATS_EN
    ,
    output logic [31:0]       hit_count,
    output logic [31:0]       miss_count
`endif
);
    localparam int TAG_WIDTH = 32 - INDEX_WIDTH - OFFSET_WIDTH - 2;
    localparam int LINES     = 1 << INDEX_WIDTH;
    localparam int WORDS     = 1 << OFFSET_WIDTH;
    localparam logic [OFFSET_WIDTH-1:0] LAST_WORD = OFFSET_WIDTH'(WORDS - 1);

    typedef enum logic [1:0] {IDLE, REFILL, RESPOND} state_t;
    state_t state;

    logic [TAG_WIDTH-1:0]    tag_ram  [LINES];
    logic [31:0]             data_ram [LINES][WORDS];
    logic [31:0]             line_buf [WORDS];
    logic [LINES-1:0]        line_valid;

    logic [TAG_WIDTH-1:0]    fill_tag;
    logic [INDEX_WIDTH-1:0]  fill_index;
    logic [OFFSET_WIDTH-1:0] req_word;
    logic [OFFSET_WIDTH-1:0] cnt;
    logic                    drop;

    logic [TAG_WIDTH-1:0]    pc_tag;
    logic [INDEX_WIDTH-1:0]  pc_index;
    logic [OFFSET_WIDTH-1:0] pc_word;
    logic                    accept;
    logic                    lookup_hit;
    logic                    fill_done;

    assign pc_tag     = bus.pc_to_icache[31 -: TAG_WIDTH];
    assign pc_index   = bus.pc_to_icache[OFFSET_WIDTH+2 +: INDEX_WIDTH];
    assign pc_word    = bus.pc_to_icache[2 +: OFFSET_WIDTH];
    assign accept     = (state == IDLE) && bus.to_icache && !bus.flush;
    assign lookup_hit = line_valid[pc_index] && (tag_ram[pc_index] == pc_tag);
    assign fill_done  = (state == REFILL) && bus.mem_ready && (cnt == LAST_WORD);

    // Arrays and request latches carry no reset; line_valid alone decides whether they mean anything.
    always_ff @(posedge clk_in) begin
        if (rdy_in) begin
            if (accept && !lookup_hit) begin
                fill_tag   <= pc_tag;
                fill_index <= pc_index;
                req_word   <= pc_word;
            end
            if ((state == REFILL) && bus.mem_ready)
                line_buf[cnt] <= bus.mem_data;
            if (fill_done) begin
                tag_ram[fill_index] <= fill_tag;
                for (int w = 0; w < WORDS; w++)
                    data_ram[fill_index][w] <= (OFFSET_WIDTH'(w) == cnt) ? bus.mem_data : line_buf[w];
            end
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state                <= IDLE;
            line_valid           <= '0;
            cnt                  <= '0;
            drop                 <= 1'b0;
            bus.have_result      <= 1'b0;
            bus.inst_from_icache <= '0;
            bus.mem_valid        <= 1'b0;
            bus.mem_addr         <= '0;
        end else if (rdy_in) begin
            bus.have_result      <= 1'b0;
            bus.inst_from_icache <= '0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (lookup_hit) begin
                            bus.have_result      <= 1'b1;
                            bus.inst_from_icache <= data_ram[pc_index][pc_word];
                        end else begin
                            state         <= REFILL;
                            cnt           <= '0;
                            drop          <= 1'b0;
                            bus.mem_valid <= 1'b1;
                            bus.mem_addr  <= {pc_tag, pc_index, {OFFSET_WIDTH{1'b0}}, 2'b00};
                        end
                    end
                end
                REFILL: begin
                    // A redirect cannot cancel the fill; it only silences the eventual response.
                    if (bus.flush)
                        drop <= 1'b1;
                    if (bus.mem_ready) begin
                        if (cnt == LAST_WORD) begin
                            bus.mem_valid          <= 1'b0;
                            line_valid[fill_index] <= 1'b1;
                            state                  <= RESPOND;
                        end else begin
                            cnt          <= cnt + OFFSET_WIDTH'(1);
                            bus.mem_addr <= bus.mem_addr + 32'd4;
                        end
                    end
                end
                RESPOND: begin
                    if (!drop && !bus.flush) begin
                        bus.have_result      <= 1'b1;
                        bus.inst_from_icache <= line_buf[req_word];
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef ICACHE_STATS_EN
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else if (rdy_in && accept) begin
            if (lookup_hit)
                hit_count  <= hit_count + 32'd1;
            else
                miss_count <= miss_count + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_icache_responder.sv
// Bench for icache_responder: transaction-level cache model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_icache_responder;
    logic clk_in = 1'b0;
    logic rst_in;
    logic rdy_in;
    always #5 clk_in = ~clk_in;

    icache_responder_if bus();
`ifdef ICACHE_STATS_EN
    logic [31:0] hit_count, miss_count;
`endif

    icache_responder dut (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .rdy_in (rdy_in),
        .bus    (bus)
`ifdef ICACHE_STATS_EN
        ,
        .hit_count  (hit_count),
        .miss_count (miss_count)
`endif
    );

    int checks = 0;
    int failures = 0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endfunction

    // Backing memory contents: fixed words for the first line, a hash elsewhere.
    function automatic logic [31:0] memfn(input logic [31:0] a);
        case (a)
            32'h10:  return 32'h11;
            32'h14:  return 32'h22;
            32'h18:  return 32'h33;
            32'h1C:  return 32'h44;
            default: return (a * 32'h9E37_79B1) ^ 32'hA5A5_0F0F;
        endcase
    endfunction

    // Inputs as seen by the DUT at the last rising edge.
    logic s_rst, s_rdy, s_req, s_flush, s_mem_ready;
    logic [31:0] s_pc;
    always @(posedge clk_in) begin
        s_rst       <= rst_in;
        s_rdy       <= rdy_in;
        s_req       <= bus.to_icache;
        s_pc        <= bus.pc_to_icache;
        s_flush     <= bus.flush;
        s_mem_ready <= bus.mem_ready;
    end

    // Transaction model: cache contents as line tags, one outstanding miss as a queue of word addresses.
    bit          m_valid [64];
    logic [21:0] m_tag   [64];
    bit          m_busy, m_resp_pend, m_dropped;
    logic [31:0] m_req_pc;
    logic [31:0] m_addr_q [$];
    logic        exp_hr, exp_mv;
    logic [31:0] exp_inst, exp_ma;
    logic [31:0] exp_hits, exp_misses;

    task automatic model_reset();
        foreach (m_valid[i]) m_valid[i] = 1'b0;
        m_busy = 0; m_resp_pend = 0; m_dropped = 0;
        m_addr_q.delete();
        exp_hr = 0; exp_inst = 0; exp_mv = 0; exp_ma = 0;
        exp_hits = 0; exp_misses = 0;
    endtask

    task automatic model_step();
        int idx;
        exp_hr = 0;
        exp_inst = 0;
        if (m_resp_pend) begin
            m_resp_pend = 0;
            if (!m_dropped && !s_flush) begin
                exp_hr = 1;
                exp_inst = memfn({m_req_pc[31:2], 2'b00});
            end
        end else if (m_busy) begin
            if (s_flush) m_dropped = 1;
            if (s_mem_ready) begin
                void'(m_addr_q.pop_front());
                if (m_addr_q.size() == 0) begin
                    idx = int'(m_req_pc[9:4]);
                    m_valid[idx] = 1;
                    m_tag[idx] = m_req_pc[31:10];
                    m_busy = 0;
                    m_resp_pend = 1;
                    exp_mv = 0;
                end else begin
                    exp_ma = m_addr_q[0];
                end
            end
        end else if (s_req && !s_flush) begin
            idx = int'(s_pc[9:4]);
            if (m_valid[idx] && m_tag[idx] == s_pc[31:10]) begin
                exp_hr = 1;
                exp_inst = memfn({s_pc[31:2], 2'b00});
                exp_hits = exp_hits + 1;
            end else begin
                exp_misses = exp_misses + 1;
                m_busy = 1;
                m_dropped = 0;
                m_req_pc = s_pc;
                for (int w = 0; w < 4; w++) m_addr_q.push_back({s_pc[31:4], 4'h0} + 32'(4 * w));
                exp_mv = 1;
                exp_ma = m_addr_q[0];
            end
        end
    endtask

    always @(negedge clk_in) begin
        if (rst_in || s_rst) model_reset();
        else if (s_rdy) model_step();
        chk("have_result", 32'(bus.have_result), 32'(exp_hr));
        chk("inst", bus.inst_from_icache, exp_inst);
        chk("mem_valid", 32'(bus.mem_valid), 32'(exp_mv));
        if (exp_mv) chk("mem_addr", bus.mem_addr, exp_ma);
`ifdef ICACHE_STATS_EN
        chk("hit_count", hit_count, exp_hits);
        chk("miss_count", miss_count, exp_misses);
`endif
    end

    // Memory responder state and cycle stepping.
    int cyc = 0;
    int wcnt = 0;
    int mem_delay = 2;
    bit rand_delay = 0;
    int last_ready_cyc = 0;
    logic [31:0] ready_log [$];

    task automatic cycle(input logic rdy, input logic req, input logic [31:0] pc, input logic fl);
        @(negedge clk_in);
        cyc++;
        rdy_in = rdy;
        bus.to_icache = req;
        bus.pc_to_icache = pc;
        bus.flush = fl;
        bus.mem_ready = 1'b0;
        bus.mem_data = $urandom;
        if (!bus.mem_valid || rst_in) begin
            wcnt = 0;
        end else if (rdy) begin
            if (wcnt >= mem_delay) begin
                bus.mem_ready = 1'b1;
                bus.mem_data = memfn(bus.mem_addr);
                ready_log.push_back(bus.mem_addr);
                last_ready_cyc = cyc;
                wcnt = 0;
                if (rand_delay) mem_delay = $urandom_range(0, 3);
            end else begin
                wcnt++;
            end
        end
    endtask

    task automatic wait_result(input string name, input int max, output int hr_cyc);
        bit got = 0;
        hr_cyc = -1;
        for (int i = 0; i < max && !got; i++) begin
            cycle(1, 0, 32'h0, 0);
            if (bus.have_result) begin
                got = 1;
                hr_cyc = cyc;
            end
        end
        if (!got) begin
            failures++;
            checks++;
            $display("FAIL %s_timeout actual=no_result required=have_result within %0d cycles", name, max);
        end
    endtask

    task automatic wait_addr(input logic [31:0] a, input int max);
        bit got = 0;
        for (int i = 0; i < max && !got; i++) begin
            cycle(1, 0, 32'h0, 0);
            if (bus.mem_valid && bus.mem_addr == a) got = 1;
        end
        if (!got) begin
            failures++;
            checks++;
            $display("FAIL wait_addr_timeout actual=%h required=%h", bus.mem_addr, a);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int hr_cyc;
        int hr_seen;
        logic [31:0] rp;
        rst_in = 1'b1;
        rdy_in = 1'b1;
        bus.to_icache = 0; bus.pc_to_icache = 0; bus.flush = 0;
        bus.mem_ready = 0; bus.mem_data = 0;
        repeat (3) cycle(1, 0, 32'h0, 0);
        chk("rst_have_result", 32'(bus.have_result), 32'h0);
        chk("rst_mem_valid", 32'(bus.mem_valid), 32'h0);
        chk("rst_mem_addr", bus.mem_addr, 32'h0);
        #2 rst_in = 1'b0;

        // Cold miss at 0x10.
        ready_log.delete();
        cycle(1, 1, 32'h10, 0);
        wait_result("cold", 60, hr_cyc);
        chk("cold_inst", bus.inst_from_icache, 32'h11);
        chk("cold_latency", 32'(hr_cyc - last_ready_cyc), 32'd2);
        chk("cold_nreq", 32'(ready_log.size()), 32'd4);
        if (ready_log.size() == 4) begin
            chk("cold_addr0", ready_log[0], 32'h10);
            chk("cold_addr1", ready_log[1], 32'h14);
            chk("cold_addr2", ready_log[2], 32'h18);
            chk("cold_addr3", ready_log[3], 32'h1C);
        end

        // Hit in the filled line.
        cycle(1, 1, 32'h18, 0);
        cycle(1, 0, 32'h0, 0);
        chk("hit_have_result", 32'(bus.have_result), 32'h1);
        chk("hit_inst", bus.inst_from_icache, 32'h33);
        chk("hit_mem_valid", 32'(bus.mem_valid), 32'h0);

        // Conflict on the same index, then the evicted line misses again.
        cycle(1, 1, 32'h410, 0);
        cycle(1, 0, 32'h0, 0);
        chk("conflict_mem_addr", bus.mem_addr, 32'h410);
        wait_result("conflict", 60, hr_cyc);
        chk("conflict_inst", bus.inst_from_icache, memfn(32'h410));
        cycle(1, 1, 32'h10, 0);
        cycle(1, 0, 32'h0, 0);
        chk("remiss_mem_valid", 32'(bus.mem_valid), 32'h1);
        wait_result("remiss", 60, hr_cyc);
        chk("remiss_inst", bus.inst_from_icache, 32'h11);

        // Flush while the second word is outstanding.
        mem_delay = 3;
        cycle(1, 1, 32'h20, 0);
        wait_addr(32'h24, 30);
        cycle(1, 0, 32'h0, 1);
        hr_seen = 0;
        for (int i = 0; i < 30; i++) begin
            cycle(1, 0, 32'h0, 0);
            if (bus.have_result) hr_seen++;
        end
        chk("flush_no_result", 32'(hr_seen), 32'h0);
        cycle(1, 1, 32'h2C, 0);
        cycle(1, 0, 32'h0, 0);
        chk("flush_hit", 32'(bus.have_result), 32'h1);
        chk("flush_hit_inst", bus.inst_from_icache, memfn(32'h2C));

        // Pause mid-refill.
        mem_delay = 2;
        cycle(1, 1, 32'h30, 0);
        wait_addr(32'h34, 30);
        for (int i = 0; i < 4; i++) begin
            cycle(i == 3, 0, 32'h0, 0);
            chk("pause_mem_valid", 32'(bus.mem_valid), 32'h1);
            chk("pause_mem_addr", bus.mem_addr, 32'h34);
        end
        wait_result("pause", 60, hr_cyc);
        chk("pause_inst", bus.inst_from_icache, memfn(32'h30));

        // Asynchronous reset in the middle of a refill.
        cycle(1, 1, 32'h40, 0);
        wait_addr(32'h40, 10);
        #2 rst_in = 1'b1;
        #1 chk("async_rst_mem_valid", 32'(bus.mem_valid), 32'h0);
        cycle(1, 0, 32'h0, 0);
        cycle(1, 0, 32'h0, 0);
        #2 rst_in = 1'b0;
        cycle(1, 1, 32'h40, 0);
        cycle(1, 0, 32'h0, 0);
        chk("after_rst_miss", 32'(bus.mem_valid), 32'h1);
        wait_result("after_rst", 60, hr_cyc);
        chk("after_rst_inst", bus.inst_from_icache, memfn(32'h40));

        // Randomized traffic over a small address set to force hits and conflicts.
        rand_delay = 1;
        for (int i = 0; i < 2000; i++) begin
            rp = (32'($urandom_range(0, 3)) << 10) | (32'($urandom_range(0, 7)) << 4) | 32'($urandom_range(0, 15));
            cycle($urandom_range(0, 9) != 0, $urandom_range(0, 9) < 4, rp, $urandom_range(0, 19) == 0);
        end
        repeat (40) cycle(1, 0, 32'h0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
